// File: rtl/acc_stack_pkg.sv
// Shared constants for the accumulator save/restore stack.
package acc_stack_pkg;

    // Accumulator word width; the stack stores exactly one accumulator value per entry.
    localparam int ACC_DATA_WIDTH = 8;

    // Default number of stack entries (power of two, 2..256).
    localparam int STACK_DEPTH = 8;

    // Control request decoded from {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

endpackage

// File: rtl/acc_stack_mem.sv
// Stack storage: synchronous single write port, asynchronous single read port.
// Contents are not reset; the owning logic tracks which entries are valid.
module acc_stack_mem
    import acc_stack_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [PTR_WIDTH-1:0]  write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [PTR_WIDTH-1:0]  read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/acc_stack.sv
// LIFO for saving/restoring the accumulator. Holds the entry count, sticky
// error flags and the registered pop port; storage lives in acc_stack_mem.
module acc_stack
    import acc_stack_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [PTR_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    // Count is one bit wider than the index so DEPTH itself is representable.
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [PTR_WIDTH:0]   CNT_FULL = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH-1:0] IDX_ONE  = 1;

    stack_op_e             op;
    logic [PTR_WIDTH-1:0]  top_idx;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  mem_we;
    logic [PTR_WIDTH-1:0]  mem_waddr;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Low index bits wrap cleanly: a full stack has low bits 0, so minus one lands on DEPTH-1.
    assign top_idx = count[PTR_WIDTH-1:0] - IDX_ONE;

    // Decode the request and steer the storage write port (new slot on push, top slot on swap).
    always_comb begin
        op        = stack_op_e'({push, pop});
        mem_we    = 1'b0;
        mem_waddr = count[PTR_WIDTH-1:0];
        if (reset) begin
            unique case (op)
                OP_PUSH: mem_we = !full;
                OP_SWAP: begin
                    mem_we    = !empty;
                    mem_waddr = top_idx;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    acc_stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clock      (clock),
        .write_en   (mem_we),
        .write_addr (mem_waddr),
        .write_data (push_data),
        .read_addr  (top_idx),
        .read_data  (top_data)
    );

    // Count, pop port and sticky flags; a same-cycle error overrides clear_errors.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (clear_errors) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            unique case (op)
                OP_PUSH: begin
                    if (full) overflow <= 1'b1;
                    else      count    <= count + CNT_ONE;
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        pop_data  <= top_data;
                        pop_valid <= 1'b1;
                        count     <= count - CNT_ONE;
                    end
                end
                OP_SWAP: begin
                    // Empty swap passes the pushed word straight through.
                    pop_data  <= empty ? push_data : top_data;
                    pop_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_stack.sv
// Self-checking bench for acc_stack: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based LIFO model.
module tb_acc_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic          clear_errors;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    acc_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .push_data    (push_data),
        .clear_errors (clear_errors),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_pd;
    logic          m_pv;
    logic          m_ov;
    logic          m_un;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic ps, input logic pp,
                              input logic [DW-1:0] d, input logic clr);
        if (!rst_n) begin
            q.delete();
            m_pd = '0; m_pv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            m_pv = 1'b0;
            if (clr) begin m_ov = 1'b0; m_un = 1'b0; end
            if (ps && pp) begin
                m_pv = 1'b1;
                if (q.size() == 0) m_pd = d;
                else begin m_pd = q[q.size()-1]; q[q.size()-1] = d; end
            end else if (ps) begin
                if (q.size() == DEPTH) m_ov = 1'b1;
                else q.push_back(d);
            end else if (pp) begin
                if (q.size() == 0) m_un = 1'b1;
                else begin m_pd = q.pop_back(); m_pv = 1'b1; end
            end
        end
    endtask

    task automatic check_all();
        chk("count",     32'(count),     32'(q.size()));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("full",      32'(full),      32'(q.size() == DEPTH));
        chk("pop_data",  32'(pop_data),  32'(m_pd));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("overflow",  32'(overflow),  32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
    endtask

    // One clock: drive inputs, clock edge, advance model, sample 1 time unit later.
    task automatic cyc(input logic rst_n, input logic ps, input logic pp,
                       input logic [DW-1:0] d, input logic clr);
        reset = rst_n; push = ps; pop = pp; push_data = d; clear_errors = clr;
        @(posedge clock);
        model_step(rst_n, ps, pp, d, clr);
        #1;
        check_all();
    endtask

    task automatic do_push(input logic [DW-1:0] d); cyc(1, 1, 0, d, 0); endtask
    task automatic do_pop();                         cyc(1, 0, 1, '0, 0); endtask
    task automatic idle();                           cyc(1, 0, 0, '0, 0); endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clear_errors = 1'b0;
        q.delete(); m_pd = '0; m_pv = 1'b0; m_ov = 1'b0; m_un = 1'b0;

        // Random pushes, then reset: everything returns to the reset state
        cyc(0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) do_push(8'($urandom));
        cyc(0, 1, 1, 8'h77, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_pdata", 32'(pop_data), 0);

        // LIFO order
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        do_pop(); chk("lifo0", 32'(pop_data), 32'h33);
        do_pop(); chk("lifo1", 32'(pop_data), 32'h22);
        do_pop(); chk("lifo2", 32'(pop_data), 32'h11);
        idle();

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) do_push(8'(i));
        do_push(8'hFF);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 8; i >= 1; i--) begin
            do_pop(); chk("drain", 32'(pop_data), 32'(i));
        end

        // Underflow, clear, clear racing a new underflow
        do_pop();
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_pdata", 32'(pop_data), 32'h01);
        cyc(1, 0, 0, '0, 1);
        chk("clr_unf", 32'(underflow), 0);
        cyc(1, 0, 1, '0, 1);
        chk("clr_set_wins", 32'(underflow), 1);
        cyc(1, 0, 0, '0, 1);

        // Swap on non-empty stack, then pass-through on empty
        do_push(8'h10); do_push(8'h20);
        cyc(1, 1, 1, 8'h99, 0);
        chk("swap_pd", 32'(pop_data), 32'h20);
        do_pop(); chk("swap_top", 32'(pop_data), 32'h99);
        do_pop();
        cyc(1, 1, 1, 8'h5A, 0);
        chk("pass_pd", 32'(pop_data), 32'h5A);

        // Swap on a full stack: no overflow, top replaced
        for (int i = 0; i < 8; i++) do_push(8'(8'hC0 + i));
        cyc(1, 1, 1, 8'hAB, 0);
        chk("fswap_pd", 32'(pop_data), 32'hC7);
        do_pop(); chk("fswap_top", 32'(pop_data), 32'hAB);

        // Random traffic, occasional resets and clears
        for (int i = 0; i < 600; i++) begin
            int r;
            logic ps, pp;
            r  = int'($urandom_range(0, 99));
            ps = (r < 45) || (r >= 85 && r < 95);
            pp = (r >= 40 && r < 95);
            cyc(($urandom_range(0, 99) != 0), ps, pp, 8'($urandom),
                ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
